board_rom_arbiter: RTL and testbench

- Shares one synchronous board ROM (64 entries, r3g3b2) between two requesters, replacing the duplicated ROM instances.
  - VGA pixel path: streaming, high priority, fixed latency.
  - Matcher: request/acknowledge handshake, low priority, starvation guard.
- Sits between vga_timing/matcher and a single board instance, in the 100 MHz domain.

---
 rtl/board_rom_arbiter.sv | 102 ++++++++++
 tb/tb_board_rom_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_rom_arbiter.sv
// Two-port arbiter in front of the single board ROM: streaming VGA reads take priority,
// and matcher handshake reads preempt VGA once they have waited STARVE_LIMIT cycles.
module board_rom_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_data,
  input  logic              m_req,
  input  logic [ADDR_W-1:0] m_addr,
  output logic              m_ack,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  // state  | meaning
  // M_IDLE | no matcher request outstanding
  // M_PEND | address latched, waiting for a ROM slot
  // M_WAIT | matcher read issued, ROM data arrives this cycle
  // M_ACK  | m_ack high, m_data valid
  // M_DONE | waiting for m_req to drop before accepting a new request
  typedef enum logic [2:0] {M_IDLE, M_PEND, M_WAIT, M_ACK, M_DONE} m_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_M} tag_t;

  // The counter saturates at 31, so larger limits are clamped to stay reachable.
  localparam logic [4:0] STARVE_LIM = (STARVE_LIMIT > 31) ? 5'd31 : STARVE_LIMIT[4:0];

  m_state_t          m_state;
  logic [4:0]        starve_cnt;
  logic [ADDR_W-1:0] m_addr_q;
  logic [ADDR_W-1:0] rom_addr_q;
  tag_t              tag_now;
  tag_t              tag_s1;
  logic              m_grant;
  logic              vga_grant;

  always_comb begin
    m_grant   = (m_state == M_PEND) && (!vga_req || (starve_cnt >= STARVE_LIM));
    vga_grant = vga_req && !m_grant;
    rom_addr  = rom_addr_q;
    tag_now   = TAG_NONE;
    if (m_grant) begin
      rom_addr = m_addr_q;
      tag_now  = TAG_M;
    end else if (vga_grant) begin
      rom_addr = vga_addr;
      tag_now  = TAG_VGA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state    <= M_IDLE;
      starve_cnt <= '0;
      m_addr_q   <= '0;
      rom_addr_q <= '0;
      tag_s1     <= TAG_NONE;
      vga_valid  <= 1'b0;
      vga_data   <= '0;
      m_ack      <= 1'b0;
      m_data     <= '0;
    end else begin
      rom_addr_q <= rom_addr;
      tag_s1     <= tag_now;

      // Output stage: rom_data belongs to whichever owner issued last cycle.
      vga_valid <= (tag_s1 == TAG_VGA);
      if (tag_s1 == TAG_VGA) vga_data <= rom_data;
      m_ack <= (tag_s1 == TAG_M);
      if (tag_s1 == TAG_M) m_data <= rom_data;

      case (m_state)
        M_IDLE: begin
          if (m_req) begin
            m_addr_q   <= m_addr;
            starve_cnt <= '0;
            m_state    <= M_PEND;
          end
        end
        M_PEND: begin
          if (m_grant) begin
            starve_cnt <= '0;
            m_state    <= M_WAIT;
          end else if (starve_cnt != 5'd31) begin
            starve_cnt <= starve_cnt + 5'd1;
          end
        end
        M_WAIT:  m_state <= M_ACK;
        M_ACK:   m_state <= M_DONE;
        M_DONE:  if (!m_req) m_state <= M_IDLE;
        default: m_state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_rom_arbiter.sv
// Directed bench for board_rom_arbiter with a behavioural 1-cycle board ROM, ROM[i] = i + 8'h10.
module tb_board_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vga_req = 1'b0;
  logic [5:0] vga_addr = '0;
  logic       vga_valid;
  logic [7:0] vga_data;
  logic       m_req = 1'b0;
  logic [5:0] m_addr = '0;
  logic       m_ack;
  logic [7:0] m_data;
  logic [5:0] rom_addr;
  logic [7:0] rom_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  board_rom_arbiter #(.ADDR_W(6), .DATA_W(8), .STARVE_LIMIT(15)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_data(vga_data),
    .m_req(m_req), .m_addr(m_addr), .m_ack(m_ack), .m_data(m_data),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= 8'h10 + {2'b00, rom_addr};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    vga_req = 0; m_req = 0; rst = 0;
    repeat (3) tick;
    n_checks++;
    if (vga_valid !== 1'b0 || vga_data !== 8'h00 || m_ack !== 1'b0 || m_data !== 8'h00 || rom_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b vdata=%h ack=%b mdata=%h addr=%0d, want all 0",
               vga_valid, vga_data, m_ack, m_data, rom_addr);
    end
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      tick;
      n_checks++;
      if (m_ack !== 1'b0 || vga_valid !== 1'b0 || rom_addr !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d: got ack=%b valid=%b addr=%0d, want 0/0/0", c, m_ack, vga_valid, rom_addr);
      end
    end
  endtask

  task automatic test_vga_stream;
    logic       exp_v;
    logic [7:0] exp_d;
    for (int c = 0; c <= 12; c++) begin
      tick;
      exp_v = (c >= 2) && (c - 2 < 10);
      exp_d = exp_v ? 8'(8'h10 + c - 2) : 8'h19;
      n_checks++;
      if (vga_valid !== exp_v || (c >= 2 && vga_data !== exp_d)) begin
        n_fail++;
        $display("FAIL vga_stream c=%0d: got valid=%b data=%h, want valid=%b data=%h", c, vga_valid, vga_data, exp_v, exp_d);
      end
      vga_req  = (c < 10);
      vga_addr = 6'(c);
      #1;
      n_checks++;
      if (rom_addr !== (c < 10 ? 6'(c) : 6'd9)) begin
        n_fail++;
        $display("FAIL vga_rom_addr c=%0d: got %0d, want %0d", c, rom_addr, (c < 10 ? c : 9));
      end
    end
    vga_req = 0;
  endtask

  task automatic test_matcher_idle;
    for (int c = 0; c <= 11; c++) begin
      tick;
      n_checks++;
      if (m_ack !== (c == 3) || vga_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL m_idle_ack c=%0d: got ack=%b valid=%b, want ack=%b valid=0", c, m_ack, vga_valid, (c == 3));
      end
      if (c == 3) begin
        n_checks++;
        if (m_data !== 8'h33) begin
          n_fail++;
          $display("FAIL m_idle_data: got %h, want 33", m_data);
        end
      end
      m_req  = (c < 8);
      m_addr = (c == 0) ? 6'd35 : 6'd0;
      #1;
      if (c == 1) begin
        n_checks++;
        if (rom_addr !== 6'd35) begin
          n_fail++;
          $display("FAIL m_idle_rom_addr: got %0d, want 35", rom_addr);
        end
      end
    end
  endtask

  task automatic test_starvation;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [5:0] exp_a;
    for (int c = 0; c <= 24; c++) begin
      tick;
      exp_v = (c >= 2) && (c <= 24) && (c - 2 != 18);
      exp_d = (c == 20) ? 8'h21 : 8'(8'h10 + c - 2);
      if (c >= 2) begin
        n_checks++;
        if (vga_valid !== exp_v || vga_data !== exp_d) begin
          n_fail++;
          $display("FAIL starve_vga c=%0d: got valid=%b data=%h, want valid=%b data=%h", c, vga_valid, vga_data, exp_v, exp_d);
        end
      end
      n_checks++;
      if (m_ack !== (c == 20) || (c >= 20 && m_data !== 8'h17)) begin
        n_fail++;
        $display("FAIL starve_ack c=%0d: got ack=%b data=%h, want ack=%b data=17", c, m_ack, m_data, (c == 20));
      end
      vga_req  = 1;
      vga_addr = 6'(c);
      m_req    = (c >= 2) && (c < 21);
      m_addr   = 6'd7;
      #1;
      exp_a = (c == 18) ? 6'd7 : 6'(c);
      n_checks++;
      if (rom_addr !== exp_a) begin
        n_fail++;
        $display("FAIL starve_rom_addr c=%0d: got %0d, want %0d", c, rom_addr, exp_a);
      end
    end
    vga_req = 0;
    repeat (3) tick;
  endtask

  task automatic test_simultaneous;
    logic exp_v;
    for (int c = 0; c <= 8; c++) begin
      tick;
      exp_v = (c >= 2) && (c <= 5);
      n_checks++;
      if (vga_valid !== exp_v || (exp_v && vga_data !== 8'(8'h10 + 20 + c - 2))) begin
        n_fail++;
        $display("FAIL simul_vga c=%0d: got valid=%b data=%h, want valid=%b data=%h", c, vga_valid, vga_data, exp_v, 8'(8'h10 + 20 + c - 2));
      end
      n_checks++;
      if (m_ack !== (c == 6) || (c == 6 && m_data !== 8'h42)) begin
        n_fail++;
        $display("FAIL simul_ack c=%0d: got ack=%b data=%h, want ack=%b data=42", c, m_ack, m_data, (c == 6));
      end
      vga_req  = (c < 4);
      vga_addr = 6'(20 + c);
      m_req    = (c < 7);
      m_addr   = 6'd50;
      #1;
      if (c <= 5) begin
        n_checks++;
        if (rom_addr !== ((c >= 4) ? 6'd50 : 6'(20 + c))) begin
          n_fail++;
          $display("FAIL simul_rom_addr c=%0d: got %0d, want %0d", c, rom_addr, ((c >= 4) ? 50 : 20 + c));
        end
      end
    end
    m_req = 0;
    repeat (2) tick;
  endtask

  task automatic test_m_req_drop;
    logic exp_v;
    for (int c = 0; c <= 12; c++) begin
      tick;
      n_checks++;
      if (m_ack !== (c == 5 || c == 10)) begin
        n_fail++;
        $display("FAIL drop_ack c=%0d: got %b, want %b", c, m_ack, (c == 5 || c == 10));
      end
      if (c == 5 || c == 10) begin
        n_checks++;
        if (m_data !== ((c == 5) ? 8'h1C : 8'h1D)) begin
          n_fail++;
          $display("FAIL drop_data c=%0d: got %h, want %h", c, m_data, ((c == 5) ? 8'h1C : 8'h1D));
        end
      end
      exp_v = (c >= 2) && (c <= 4);
      n_checks++;
      if (vga_valid !== exp_v) begin
        n_fail++;
        $display("FAIL drop_vga c=%0d: got %b, want %b", c, vga_valid, exp_v);
      end
      vga_req  = (c < 3);
      vga_addr = 6'(30 + c);
      m_req    = (c < 2) || (c >= 7 && c < 11);
      m_addr   = (c < 7) ? 6'd12 : 6'd13;
      #1;
      if (c == 3) begin
        n_checks++;
        if (rom_addr !== 6'd12) begin
          n_fail++;
          $display("FAIL drop_rom_addr: got %0d, want 12", rom_addr);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    tick;
    m_req = 1; m_addr = 6'd40; vga_req = 0;
    tick;
    #1;
    n_checks++;
    if (rom_addr !== 6'd40) begin
      n_fail++;
      $display("FAIL rmid_grant: got rom_addr=%0d, want 40", rom_addr);
    end
    tick;
    vga_req = 1; vga_addr = 6'd5;
    #2;
    rst = 0;
    #1;
    n_checks++;
    if (m_ack !== 1'b0 || vga_valid !== 1'b0 || m_data !== 8'h00 || vga_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_async: got ack=%b valid=%b mdata=%h vdata=%h, want all 0", m_ack, vga_valid, m_data, vga_data);
    end
    m_req = 0; vga_req = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      n_checks++;
      if (m_ack !== 1'b0 || vga_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_discard c=%0d: got ack=%b valid=%b, want 0/0", c, m_ack, vga_valid);
      end
      if (c == 1) rst = 1;
    end
    for (int c = 0; c <= 5; c++) begin
      tick;
      n_checks++;
      if (m_ack !== (c == 3) || (c == 3 && m_data !== 8'h38)) begin
        n_fail++;
        $display("FAIL rmid_rereq c=%0d: got ack=%b data=%h, want ack=%b data=38", c, m_ack, m_data, (c == 3));
      end
      if (c == 0) begin m_req = 1; m_addr = 6'd40; end
      if (c == 5) m_req = 0;
    end
  endtask

  initial begin
    test_reset;
    test_vga_stream;
    test_matcher_idle;
    test_starvation;
    test_simultaneous;
    test_m_req_drop;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
